cdc_bus_tx_arbiter: RTL and testbench

CDC_BUS_TX_ARBITER -- requirements
Module: cdc_bus_tx_arbiter

---
 rtl/cdc_bus_tx_arbiter_pkg.sv | 12 +
 rtl/cdc_bus_tx_arbiter_rr_arbiter.sv | 32 +++
 rtl/cdc_bus_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_cdc_bus_tx_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cdc_bus_tx_arbiter_pkg.sv
// Shared definitions for the CDC bus transmit arbiter: FSM encoding and counter width.
package cdc_bus_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int CNT_W = 8;

endpackage

// File: rtl/cdc_bus_tx_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
// Returns a one-hot grant and the index of the granted requester.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic found;
  int   idx;

  // First requester at or after ptr, in wrapping order, wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_bus_tx_arbiter.sv
// Round-robin transmit arbiter that drives one word at a time across a
// clock-domain crossing: bus_data is held stable while bus_enable is high for
// HOLD_CYCLES, then bus_enable stays low for GAP_CYCLES so the receiving
// synchronizer sees a clean rising edge per word.
module cdc_bus_tx_arbiter
  import cdc_bus_tx_arbiter_pkg::*;
#(
  parameter int dataWidth   = 8,
  parameter int N_REQ       = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*dataWidth-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [dataWidth-1:0]       bus_data,
  output logic                       bus_enable,
  output logic                       busy,
  output logic [7:0]                 tx_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..255");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("GAP_CYCLES must be in 1..255");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("N_REQ must be in 2..8");
  end

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [dataWidth-1:0] bus_data_q, bus_data_d;
  logic                 bus_en_q, bus_en_d;
  logic                 busy_q, busy_d;
  logic [7:0]           tx_count_q, tx_count_d;

  logic [N_REQ-1:0]     grant;
  logic [IDX_W-1:0]     grant_idx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is only offered in IDLE and never while reset is held
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && rst) begin
      req_ready = grant;
    end
  end

  // Next-state logic: accept a word in IDLE, count out HOLD then GAP
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    bus_data_d = bus_data_q;
    bus_en_d   = bus_en_q;
    tx_count_d = tx_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          bus_data_d = req_data[int'(grant_idx)*dataWidth +: dataWidth];
          bus_en_d   = 1'b1;
          cnt_d      = CNT_W'(HOLD_CYCLES - 1);
          ptr_d      = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
          tx_count_d = tx_count_q + 8'd1;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          bus_en_d = 1'b0;
          cnt_d    = CNT_W'(GAP_CYCLES - 1);
          state_d  = ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        bus_en_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // All state and outputs registered; reset drops everything immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      bus_data_q <= '0;
      bus_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      tx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      bus_data_q <= bus_data_d;
      bus_en_q   <= bus_en_d;
      busy_q     <= busy_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign bus_data   = bus_data_q;
  assign bus_enable = bus_en_q;
  assign busy       = busy_q;
  assign tx_count   = tx_count_q;

endmodule

// File: tb/tb_cdc_bus_tx_arbiter.sv
// Directed self-checking bench for cdc_bus_tx_arbiter at default parameters.
module tb_cdc_bus_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [7:0]  bus_data;
  logic        bus_enable;
  logic        busy;
  logic [7:0]  tx_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  cdc_bus_tx_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .bus_data   (bus_data),
    .bus_enable (bus_enable),
    .busy       (busy),
    .tx_count   (tx_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30; k++) begin
      if (!busy) break;
      tick();
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] en_s;
    int         hi;
    int         bad;
    int         last;
    int         edges;
    int         k;
    logic       prev_en;

    // ---------------- reset state ----------------
    rst       = 1'b0;
    req_valid = 2'b11;
    req_data  = 16'h0000;
    tick();
    tick();
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_bus_enable", {31'd0, bus_enable}, 32'd0);
    chk("rst_bus_data", {24'd0, bus_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx_count", {24'd0, tx_count}, 32'd0);
    req_valid = 2'b00;
    rst       = 1'b1;
    tick();
    chk("idle_no_valid_ready", {30'd0, req_ready}, 32'd0);

    // ---------------- single word A5 ----------------
    req_valid = 2'b01;
    req_data  = 16'h00A5;
    #1;
    chk("a_ready", {30'd0, req_ready}, 32'd1);
    chk("a_en_before", {31'd0, bus_enable}, 32'd0);
    tick();
    req_valid = 2'b00;
    hi  = 0;
    bad = 0;
    for (int j = 0; j < 9; j++) begin
      if (j > 0) tick();
      en_s[j] = bus_enable;
      if (bus_enable) hi++;
      if (bus_data !== 8'hA5) bad++;
    end
    chk("a_en_first", {31'd0, en_s[0]}, 32'd1);
    chk("a_en_last_hold", {31'd0, en_s[3]}, 32'd1);
    chk("a_en_first_gap", {31'd0, en_s[4]}, 32'd0);
    chk("a_hi_cycles", hi, 32'd4);
    chk("a_data_stable", bad, 32'd0);
    chk("a_tx_count", {24'd0, tx_count}, 32'd1);
    chk("a_busy_end", {31'd0, busy}, 32'd0);

    // ---------------- fairness: requester 1 alone, then both ----------------
    req_valid = 2'b10;
    req_data  = 16'h5A00;
    #1;
    chk("f_ready_r1", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    chk("f_bus_data", {24'd0, bus_data}, 32'h5A);
    wait_idle();

    // ---------------- contention 11/22 ----------------
    req_valid = 2'b11;
    req_data  = 16'h2211;
    #1;
    last = 0;
    for (int w = 0; w < 4; w++) begin
      k = 0;
      while (req_ready == 2'b00 && k < 20) begin
        tick();
        k++;
      end
      chk((w == 0) ? "fair_grant_r0" : "cont_grant", {30'd0, req_ready},
          (w % 2 == 1) ? 32'd2 : 32'd1);
      if (w > 0) chk("cont_period", cyc - last, 32'd9);
      last = cyc;
      tick();
      if (w == 3) req_valid = 2'b00;
      chk("cont_data", {24'd0, bus_data}, (w % 2 == 1) ? 32'h22 : 32'h11);
    end
    chk("cont_tx_count", {24'd0, tx_count}, 32'd6);
    wait_idle();

    // ---------------- data change during hold ----------------
    req_valid = 2'b01;
    req_data  = 16'h003C;
    #1;
    chk("d_ready", {30'd0, req_ready}, 32'd1);
    tick();
    tick();
    req_data = 16'h00FF;
    #1;
    chk("d_hold_data", {24'd0, bus_data}, 32'h3C);
    chk("d_hold_ready", {30'd0, req_ready}, 32'd0);
    tick();
    chk("d_hold_data2", {24'd0, bus_data}, 32'h3C);
    req_valid = 2'b00;
    for (int j = 0; j < 4; j++) tick();
    chk("d_gap_en", {31'd0, bus_enable}, 32'd0);
    chk("d_gap_data", {24'd0, bus_data}, 32'h3C);
    wait_idle();

    // ---------------- reset mid-HOLD ----------------
    req_valid = 2'b10;
    req_data  = 16'h7700;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    chk("r_in_hold_en", {31'd0, bus_enable}, 32'd1);
    rst = 1'b0;
    #1;
    chk("r_async_en", {31'd0, bus_enable}, 32'd0);
    chk("r_async_busy", {31'd0, busy}, 32'd0);
    chk("r_async_tx_count", {24'd0, tx_count}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("r_no_resend", {31'd0, bus_enable}, 32'd0);
    req_valid = 2'b11;
    #1;
    chk("r_grant_r0", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    tick();
    chk("r_drop_no_send", {24'd0, tx_count}, 32'd0);
    req_valid = 2'b11;
    #1;
    chk("r_drop_ptr_kept", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    tick();

    // ---------------- 256-word wrap ----------------
    req_valid = 2'b01;
    req_data  = 16'h00C3;
    edges     = 0;
    prev_en   = bus_enable;
    for (int c = 0; c < 256 * 9 + 50; c++) begin
      tick();
      if (bus_enable && !prev_en) begin
        edges++;
        if (edges == 128) chk("w_tx_count_128", {24'd0, tx_count}, 32'd128);
      end
      prev_en = bus_enable;
      if (edges == 256) break;
    end
    req_valid = 2'b00;
    chk("w_edges", edges, 32'd256);
    chk("w_tx_count_wrap", {24'd0, tx_count}, 32'd0);
    wait_idle();
    chk("w_tx_count_after", {24'd0, tx_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
